execute_stage_param: RTL and testbench

Parametrised, registered execute stage for the RISC pipeline. Takes one decoded instruction per cycle from the ID/EX boundary, computes the ALU result and updates the condition-flag register (Z/N/C). It also maintains the stack pointer for push/pop. All results are presented through a valid/ready output register to the memory stage. Flags and SP commit only on accepted, non-flushed instructions, so stalls and flushes never double-apply side effects.

---
 rtl/execute_stage_param_if.sv | 57 +++++
 rtl/execute_stage_param.sv | 196 +++++++++++++++++++
 tb/tb_execute_stage_param.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_param_if.sv
// execute_stage_param_if: bundles the ID/EX input bus, the flush strobe and
// the registered EX/MEM output bus of the execute stage.
interface execute_stage_param_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int SP_W   = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic              zero_a;
    logic              use_imm;
    logic [3:0]        alu_op;
    logic              flag_we;
    logic [REG_AW-1:0] rsrc_addr;
    logic [REG_AW-1:0] rdst_addr;
    logic [1:0]        mem_ctl;
    logic [1:0]        sp_op;
    logic              wb_en;
    logic              ldd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_src_value;
    logic [SP_W-1:0]   out_sp_addr;
    logic [REG_AW-1:0] out_rsrc_addr;
    logic [REG_AW-1:0] out_rdst_addr;
    logic [1:0]        out_mem_ctl;
    logic [1:0]        out_sp_op;
    logic              out_wb_en;
    logic              out_ldd;
    logic [2:0]        flags;

    // Execute stage side: consumes the instruction, produces the result beat.
    modport slave (
        input  flush, in_valid, op_a, op_b, imm, zero_a, use_imm, alu_op,
               flag_we, rsrc_addr, rdst_addr, mem_ctl, sp_op, wb_en, ldd,
               out_ready,
        output in_ready, out_valid, out_result, out_src_value, out_sp_addr,
               out_rsrc_addr, out_rdst_addr, out_mem_ctl, out_sp_op,
               out_wb_en, out_ldd, flags
    );

    // Pipeline environment side: decode drives instructions, memory drains.
    modport master (
        output flush, in_valid, op_a, op_b, imm, zero_a, use_imm, alu_op,
               flag_we, rsrc_addr, rdst_addr, mem_ctl, sp_op, wb_en, ldd,
               out_ready,
        input  in_ready, out_valid, out_result, out_src_value, out_sp_addr,
               out_rsrc_addr, out_rdst_addr, out_mem_ctl, out_sp_op,
               out_wb_en, out_ldd, flags
    );
endinterface

// File: rtl/execute_stage_param.sv
// execute_stage_param: registered execute stage. Computes the ALU result,
// commits Z/N/C flags and the stack pointer only on accepted, non-flushed
// instructions, and presents the result through a valid/ready register.
module execute_stage_param #(
    parameter int              DATA_W  = 16,
    parameter int              REG_AW  = 3,
    parameter int              SP_W    = 32,
    parameter logic [SP_W-1:0] SP_INIT = SP_W'(20'hFFFFF)
) (
    input logic                  clk,
    input logic                  rst_n,
    execute_stage_param_if.slave bus
);

    localparam int SHW = $clog2(DATA_W);
    localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};
    localparam logic [SP_W-1:0] ONE_SP = {{(SP_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        OP_PASS_A = 4'd0,
        OP_PASS_B = 4'd1,
        OP_ADD    = 4'd2,
        OP_SUB    = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_NOT    = 4'd6,
        OP_INC    = 4'd7,
        OP_DEC    = 4'd8,
        OP_SHL    = 4'd9,
        OP_SHR    = 4'd10,
        OP_SETC   = 4'd11,
        OP_CLRC   = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10
    } sp_op_e;

    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] src_q;
    logic [SP_W-1:0]   sp_addr_q;
    logic [REG_AW-1:0] rsrc_q;
    logic [REG_AW-1:0] rdst_q;
    logic [1:0]        mem_ctl_q;
    logic [1:0]        sp_op_q;
    logic              wb_en_q;
    logic              ldd_q;
    logic [2:0]        flags_q;
    logic [SP_W-1:0]   sp_q;

    logic [DATA_W-1:0] a_eff;
    logic [DATA_W-1:0] b_eff;
    logic [SHW-1:0]    shamt;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_flag_op;
    logic [SP_W-1:0]   sp_next;
    logic [SP_W-1:0]   sp_addr_next;
    logic              ready_w;
    logic              accept;

    // The stage can take a new instruction whenever its output slot is free
    // or is being drained this cycle; never depends on in_valid.
    assign ready_w = !valid_q || bus.out_ready;
    assign accept  = bus.in_valid && ready_w && !bus.flush;

    // ALU: operand selection, result and carry; the extra top bit of 'wide'
    // holds carry/borrow or the last bit shifted out.
    always_comb begin
        a_eff       = bus.zero_a ? '0 : bus.op_a;
        b_eff       = bus.use_imm ? bus.imm : bus.op_b;
        shamt       = b_eff[SHW-1:0];
        wide        = '0;
        alu_res     = '0;
        alu_c       = flags_q[2];
        alu_flag_op = 1'b1;
        case (bus.alu_op)
            OP_PASS_A: alu_res = a_eff;
            OP_PASS_B: alu_res = b_eff;
            OP_ADD: begin
                wide    = {1'b0, a_eff} + {1'b0, b_eff};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SUB: begin
                wide    = {1'b0, a_eff} - {1'b0, b_eff};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_AND:    alu_res = a_eff & b_eff;
            OP_OR:     alu_res = a_eff | b_eff;
            OP_NOT:    alu_res = ~a_eff;
            OP_INC: begin
                wide    = {1'b0, a_eff} + ONE_W;
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_DEC: begin
                wide    = {1'b0, a_eff} - ONE_W;
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SHL: begin
                wide    = {1'b0, a_eff} << shamt;
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SHR: begin
                wide    = {a_eff, 1'b0} >> shamt;
                alu_res = wide[DATA_W:1];
                alu_c   = wide[0];
            end
            OP_SETC: begin
                alu_res = a_eff;
                alu_c   = 1'b1;
            end
            OP_CLRC: begin
                alu_res = a_eff;
                alu_c   = 1'b0;
            end
            default: alu_flag_op = 1'b0;
        endcase
    end

    // Stack pointer arithmetic: push addresses the old top then decrements,
    // pop increments then addresses the new top; reserved code is a no-op.
    always_comb begin
        sp_next      = sp_q;
        sp_addr_next = sp_q;
        case (bus.sp_op)
            SP_PUSH: sp_next = sp_q - ONE_SP;
            SP_POP: begin
                sp_next      = sp_q + ONE_SP;
                sp_addr_next = sp_q + ONE_SP;
            end
            default: sp_next = sp_q;
        endcase
    end

    // Output register, flags and SP: reset beats flush beats accept/drain;
    // side effects only land on the accepting edge. The idle address
    // register starts at the stack top so it tracks the current SP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            src_q     <= '0;
            sp_addr_q <= SP_INIT;
            rsrc_q    <= '0;
            rdst_q    <= '0;
            mem_ctl_q <= '0;
            sp_op_q   <= '0;
            wb_en_q   <= 1'b0;
            ldd_q     <= 1'b0;
            flags_q   <= '0;
            sp_q      <= SP_INIT;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            result_q  <= alu_res;
            src_q     <= bus.op_a;
            sp_addr_q <= sp_addr_next;
            rsrc_q    <= bus.rsrc_addr;
            rdst_q    <= bus.rdst_addr;
            mem_ctl_q <= bus.mem_ctl;
            sp_op_q   <= bus.sp_op;
            wb_en_q   <= bus.wb_en;
            ldd_q     <= bus.ldd;
            sp_q      <= sp_next;
            if (bus.flag_we && alu_flag_op) begin
                flags_q <= {alu_c, alu_res[DATA_W-1], alu_res == '0};
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = ready_w;
    assign bus.out_valid     = valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_src_value = src_q;
    assign bus.out_sp_addr   = sp_addr_q;
    assign bus.out_rsrc_addr = rsrc_q;
    assign bus.out_rdst_addr = rdst_q;
    assign bus.out_mem_ctl   = mem_ctl_q;
    assign bus.out_sp_op     = sp_op_q;
    assign bus.out_wb_en     = wb_en_q;
    assign bus.out_ldd       = ldd_q;
    assign bus.flags         = flags_q;

endmodule

// File: tb/tb_execute_stage_param.sv
// tb_execute_stage_param: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_execute_stage_param;

    localparam int          DW  = 16;
    localparam int          RAW = 3;
    localparam int          SPW = 32;
    localparam logic [31:0] SPI = 32'h000FFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    execute_stage_param_if #(.DATA_W(DW), .REG_AW(RAW), .SP_W(SPW)) bus();

    execute_stage_param #(.DATA_W(DW), .REG_AW(RAW), .SP_W(SPW), .SP_INIT(SPI)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic [15:0] result;
        logic [15:0] src;
        logic [31:0] spaddr;
        logic [2:0]  rsrc;
        logic [2:0]  rdst;
        logic [1:0]  memctl;
        logic [1:0]  spop;
        logic        wben;
        logic        ldd;
    } beat_t;

    beat_t       mBeat;
    bit          mValid  = 0;
    logic [2:0]  mFlags  = 3'b000;
    logic [31:0] mSp     = SPI;
    bit          started = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference ALU from the operation table, using plain integer arithmetic.
    function automatic void refAlu(input int op, input int unsigned a, input int unsigned b,
                                   input logic cin, output logic [15:0] res, output logic cout,
                                   output bit writes);
        int unsigned r;
        int unsigned sh;
        writes = 1;
        cout   = cin;
        r      = 0;
        case (op)
            0: r = a;
            1: r = b;
            2: begin r = (a + b) & 32'hFFFF; cout = (a + b) > 32'hFFFF; end
            3: begin r = (a + 32'h10000 - b) & 32'hFFFF; cout = (a < b); end
            4: r = a & b;
            5: r = a | b;
            6: r = (~a) & 32'hFFFF;
            7: begin r = (a + 1) & 32'hFFFF; cout = (a == 32'hFFFF); end
            8: begin r = (a + 32'hFFFF) & 32'hFFFF; cout = (a == 0); end
            9: begin
                sh = b % 16; r = a; cout = 0;
                for (int i = 0; i < int'(sh); i++) begin
                    cout = ((r >> 15) & 1) != 0;
                    r = (r << 1) & 32'hFFFF;
                end
            end
            10: begin
                sh = b % 16; r = a; cout = 0;
                for (int i = 0; i < int'(sh); i++) begin
                    cout = (r & 1) != 0;
                    r = r >> 1;
                end
            end
            11: begin r = a; cout = 1; end
            12: begin r = a; cout = 0; end
            default: begin r = 0; writes = 0; end
        endcase
        res = r[15:0];
    endfunction

    // Reference model: advances on every rising edge from the inputs in force.
    always @(posedge clk) begin
        int unsigned a, b;
        logic [15:0] res;
        logic        cout;
        bit          writes;
        logic [31:0] addr;
        if (!rst_n) begin
            mValid = 0; mFlags = 3'b000; mSp = SPI;
            mBeat = '{default: '0};
            mBeat.spaddr = SPI;
            started = 1;
        end else if (bus.flush) begin
            mValid = 0;
        end else if (bus.in_valid && (!mValid || bus.out_ready)) begin
            a = bus.zero_a ? 0 : int'(bus.op_a);
            b = bus.use_imm ? int'(bus.imm) : int'(bus.op_b);
            refAlu(int'(bus.alu_op), a, b, mFlags[2], res, cout, writes);
            if (writes && bus.flag_we) mFlags = {cout, res[15], res == 16'd0};
            addr = mSp;
            if (bus.sp_op == 2'b01) mSp = mSp - 1;
            else if (bus.sp_op == 2'b10) begin mSp = mSp + 1; addr = mSp; end
            mBeat.result = res;
            mBeat.src    = bus.op_a;
            mBeat.spaddr = addr;
            mBeat.rsrc   = bus.rsrc_addr;
            mBeat.rdst   = bus.rdst_addr;
            mBeat.memctl = bus.mem_ctl;
            mBeat.spop   = bus.sp_op;
            mBeat.wben   = bus.wb_en;
            mBeat.ldd    = bus.ldd;
            mValid = 1;
        end else if (mValid && bus.out_ready) begin
            mValid = 0;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("in_ready", bus.in_ready, !mValid || bus.out_ready);
            checkOutput("out_valid", bus.out_valid, mValid);
            checkOutput("flags", bus.flags, mFlags);
            if (mValid) begin
                checkOutput("out_result", bus.out_result, mBeat.result);
                checkOutput("out_src_value", bus.out_src_value, mBeat.src);
                checkOutput("out_sp_addr", bus.out_sp_addr, mBeat.spaddr);
                checkOutput("out_rsrc_addr", bus.out_rsrc_addr, mBeat.rsrc);
                checkOutput("out_rdst_addr", bus.out_rdst_addr, mBeat.rdst);
                checkOutput("out_mem_ctl", bus.out_mem_ctl, mBeat.memctl);
                checkOutput("out_sp_op", bus.out_sp_op, mBeat.spop);
                checkOutput("out_wb_en", bus.out_wb_en, mBeat.wben);
                checkOutput("out_ldd", bus.out_ldd, mBeat.ldd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] im, input logic ui, input logic [1:0] sp,
                                 input logic fw);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.imm       = im;
        bus.use_imm   = ui;
        bus.zero_a    = 1'b0;
        bus.sp_op     = sp;
        bus.flag_we   = fw;
        bus.rsrc_addr = 3'($urandom_range(0, 7));
        bus.rdst_addr = 3'($urandom_range(0, 7));
        bus.mem_ctl   = 2'($urandom_range(0, 3));
        bus.wb_en     = 1'($urandom_range(0, 1));
        bus.ldd       = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.op_a = 0; bus.op_b = 0; bus.imm = 0; bus.zero_a = 0; bus.use_imm = 0;
        bus.alu_op = 0; bus.flag_we = 0; bus.rsrc_addr = 0; bus.rdst_addr = 0;
        bus.mem_ctl = 0; bus.sp_op = 0; bus.wb_en = 0; bus.ldd = 0;
        rst_n = 0;
        step(); step();
        checkOutput("reset out_valid", bus.out_valid, 1'b0);
        checkOutput("reset flags", bus.flags, 3'b000);
        checkOutput("reset out_sp_addr", bus.out_sp_addr, 32'h000FFFFF);
        checkOutput("reset in_ready", bus.in_ready, 1'b1);
        rst_n = 1;

        applyStimulus(4'd2, 16'hFFFF, 16'h0001, 16'h0, 0, 2'b00, 1); step();
        checkOutput("add result", bus.out_result, 16'h0000);
        checkOutput("add flags", bus.flags, 3'b101);
        applyStimulus(4'd12, 16'h8000, 16'h0, 16'h0, 0, 2'b00, 1); step();
        checkOutput("clrc result", bus.out_result, 16'h8000);
        checkOutput("clrc flags", bus.flags, 3'b010);
        applyStimulus(4'd3, 16'h0003, 16'h7777, 16'h0005, 1, 2'b00, 1); step();
        checkOutput("sub imm result", bus.out_result, 16'hFFFE);
        checkOutput("sub imm flags", bus.flags, 3'b110);
        applyStimulus(4'd0, 16'h0000, 16'h0, 16'h0, 0, 2'b00, 1); step();
        checkOutput("pass zero flags", bus.flags, 3'b101);
        applyStimulus(4'd3, 16'h0003, 16'h7777, 16'h0005, 1, 2'b00, 0); step();
        checkOutput("sub nowe result", bus.out_result, 16'hFFFE);
        checkOutput("sub nowe flags", bus.flags, 3'b101);

        applyStimulus(4'd0, 16'h00AA, 16'h0, 16'h0, 0, 2'b01, 0); step();
        checkOutput("push addr", bus.out_sp_addr, 32'h000FFFFF);
        applyStimulus(4'd0, 16'h0000, 16'h0, 16'h0, 0, 2'b10, 0); step();
        checkOutput("pop addr", bus.out_sp_addr, 32'h000FFFFF);
        applyStimulus(4'd0, 16'h0001, 16'h0, 16'h0, 0, 2'b00, 0); step();
        checkOutput("sp after push/pop", bus.out_sp_addr, 32'h000FFFFF);

        bus.in_valid = 0; step();
        applyStimulus(4'd1, 16'h0, 16'h1234, 16'h0, 0, 2'b00, 0);
        bus.out_ready = 0; step();
        checkOutput("stall first valid", bus.out_valid, 1'b1);
        applyStimulus(4'd0, 16'h0055, 16'h0, 16'h0, 0, 2'b01, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall in_ready", bus.in_ready, 1'b0);
            checkOutput("stall held result", bus.out_result, 16'h1234);
        end
        bus.out_ready = 1; step();
        checkOutput("stalled push result", bus.out_result, 16'h0055);
        checkOutput("stalled push addr", bus.out_sp_addr, 32'h000FFFFF);
        applyStimulus(4'd0, 16'h0001, 16'h0, 16'h0, 0, 2'b00, 0); step();
        checkOutput("sp once after stall", bus.out_sp_addr, 32'h000FFFFE);

        applyStimulus(4'd2, 16'h0001, 16'h0001, 16'h0, 0, 2'b01, 1);
        bus.flush = 1; step(); bus.flush = 0;
        checkOutput("flush out_valid", bus.out_valid, 1'b0);
        checkOutput("flush flags", bus.flags, 3'b101);
        applyStimulus(4'd0, 16'h0001, 16'h0, 16'h0, 0, 2'b00, 0); step();
        checkOutput("flush sp kept", bus.out_sp_addr, 32'h000FFFFE);

        applyStimulus(4'd2, 16'hFFFF, 16'h0001, 16'h0, 0, 2'b01, 1);
        rst_n = 0; step();
        checkOutput("midreset out_valid", bus.out_valid, 1'b0);
        checkOutput("midreset flags", bus.flags, 3'b000);
        checkOutput("midreset sp", bus.out_sp_addr, 32'h000FFFFF);
        rst_n = 1;
        applyStimulus(4'd0, 16'h0001, 16'h0, 16'h0, 0, 2'b00, 0); step();
        checkOutput("post reset sp", bus.out_sp_addr, 32'h000FFFFF);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
                          pickOperand(), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            bus.zero_a    = ($urandom_range(0, 7) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            rst_n         = !($urandom_range(0, 199) == 0);
            step();
        end

        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1; rst_n = 1;
        step(); step();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
